// File: rtl/my_cla.sv
// ---------------------------------------------------------------------------
// my_cla : 4-bit carry-lookahead adder slice with registered outputs.
//
// Computes the modulo-16 sum of A + B + CIN in flat lookahead form, with no
// ripple chain. It also computes the group generate / group propagate pair,
// so several slices can sit under a second-level lookahead unit. All outputs
// are captured on the rising CLK edge, giving a 1-cycle latency. A new
// operand set is accepted every cycle.
//
// Ports:
//   CLK   in   1  clock, outputs update on the rising edge
//   RST   in   1  asynchronous reset, active-high (clears all outputs)
//   A     in   4  operand A, unsigned
//   B     in   4  operand B, unsigned
//   CIN   in   1  carry into bit 0
//   S     out  4  registered sum, (A+B+CIN) mod 16
//   Gg    out  1  registered group generate (independent of CIN)
//   Pg    out  1  registered group propagate (independent of CIN)
//   COUT  out  1  registered carry-out, only when MY_CLA_COUT_EN is defined
//
// Build option:
//   MY_CLA_COUT_EN - adds the COUT port, equal to Gg | (Pg & CIN).
// ---------------------------------------------------------------------------
module my_cla (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       CIN,
    output logic [3:0] S,
    output logic       Gg,
    output logic       Pg
`ifdef MY_CLA_COUT_EN
    ,
    output logic       COUT
`endif
);

    // Per-bit generate/propagate and internal carries
    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [3:0] c_s;

    // Next-state values for the output registers
    logic [3:0] s_d;
    logic       gg_d;
    logic       pg_d;

    // Output registers
    logic [3:0] s_q;
    logic       gg_q;
    logic       pg_q;

`ifdef MY_CLA_COUT_EN
    logic       cout_d;
    logic       cout_q;
`endif

    // Per-bit terms. Propagate is XOR, not OR. This makes Gg and Pg mutually
    // exclusive, and lets the same p feed the sum.
    always_comb begin
        g_s = A & B;
        p_s = A ^ B;
    end

    // Carries, expanded two-level so no carry depends on another carry
    always_comb begin
        c_s    = 4'b0000;
        c_s[0] = CIN;
        c_s[1] = g_s[0]
               | (p_s[0] & CIN);
        c_s[2] = g_s[1]
               | (p_s[1] & g_s[0])
               | (p_s[1] & p_s[0] & CIN);
        c_s[3] = g_s[2]
               | (p_s[2] & g_s[1])
               | (p_s[2] & p_s[1] & g_s[0])
               | (p_s[2] & p_s[1] & p_s[0] & CIN);
    end

    // Sum bits and group terms. The group terms deliberately exclude CIN,
    // because the next lookahead level supplies the slice carry itself.
    always_comb begin
        s_d  = p_s ^ c_s;
        gg_d = g_s[3]
             | (p_s[3] & g_s[2])
             | (p_s[3] & p_s[2] & g_s[1])
             | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
        pg_d = p_s[3] & p_s[2] & p_s[1] & p_s[0];
    end

`ifdef MY_CLA_COUT_EN
    // Slice carry-out, formed from the group terms and the local carry-in
    always_comb begin
        cout_d = gg_d | (pg_d & CIN);
    end
`endif

    // Output registers. Reset clears them at once and discards any result
    // in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s_q  <= 4'b0000;
            gg_q <= 1'b0;
            pg_q <= 1'b0;
`ifdef MY_CLA_COUT_EN
            cout_q <= 1'b0;
`endif
        end else begin
            s_q  <= s_d;
            gg_q <= gg_d;
            pg_q <= pg_d;
`ifdef MY_CLA_COUT_EN
            cout_q <= cout_d;
`endif
        end
    end

    // Drive the ports straight from the registers
    assign S  = s_q;
    assign Gg = gg_q;
    assign Pg = pg_q;
`ifdef MY_CLA_COUT_EN
    assign COUT = cout_q;
`endif

endmodule

// File: tb/tb_my_cla.sv
// ---------------------------------------------------------------------------
// tb_my_cla : self-checking bench for my_cla.
//
// Expected results come from an arithmetic reference model:
//   - the sum and carry-out come from a 5-bit A+B+CIN;
//   - Gg is "A+B overflows 4 bits";
//   - Pg is "A+B equals 15".
// Expected results are pushed to a scoreboard queue when the inputs are
// driven. They are popped and compared one cycle later.
//
// In the default build there is no COUT port. The carry-out is then rebuilt
// as Gg | (Pg & CIN), which also checks the group-term invariant.
// ---------------------------------------------------------------------------
module tb_my_cla;

    typedef struct packed {
        logic [3:0] s;
        logic       gg;
        logic       pg;
        logic       co;
    } res_t;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s_o;
    logic       gg_o;
    logic       pg_o;
`ifdef MY_CLA_COUT_EN
    logic       cout_o;
`endif

    res_t sb[$];
    int   n_vec;
    int   n_err;

    my_cla dut (
        .CLK (clk),
        .RST (rst),
        .A   (a),
        .B   (b),
        .CIN (cin),
        .S   (s_o),
        .Gg  (gg_o),
        .Pg  (pg_o)
`ifdef MY_CLA_COUT_EN
        ,
        .COUT(cout_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference for one operand set
    function automatic res_t model(input logic [3:0] ma, input logic [3:0] mb,
                                   input logic mc);
        res_t       r;
        logic [4:0] full;
        logic [4:0] ab;
        full = {1'b0, ma} + {1'b0, mb} + {4'b0000, mc};
        ab   = {1'b0, ma} + {1'b0, mb};
        r.s  = full[3:0];
        r.co = full[4];
        r.gg = (ab >= 5'd16);
        r.pg = (ab == 5'd15);
        return r;
    endfunction

    // Current DUT outputs. The carry-out is rebuilt from the group terms when
    // there is no COUT port.
    function automatic res_t observe(input logic oc);
        res_t r;
        r.s  = s_o;
        r.gg = gg_o;
        r.pg = pg_o;
`ifdef MY_CLA_COUT_EN
        r.co = cout_o;
`else
        r.co = gg_o | (pg_o & oc);
`endif
        return r;
    endfunction

    task automatic test_reset();
        res_t obs;
        res_t exp;
        rst = 1'b1;
        a   = 4'($urandom_range(15, 0));
        b   = 4'($urandom_range(15, 0));
        cin = 1'b1;
        #1;
        obs = observe(1'b0);
        n_vec++;
        if (obs !== 7'b0000000) begin
            n_err++;
            $display("FAIL reset_async: got %b required 0000000", obs);
        end
        @(posedge clk);
        #1;
        obs = observe(1'b0);
        n_vec++;
        if (obs !== 7'b0000000) begin
            n_err++;
            $display("FAIL reset_hold: got %b required 0000000", obs);
        end
        #1;
        rst = 1'b0;
        a   = 4'd3;
        b   = 4'd4;
        cin = 1'b0;
        sb.push_back(model(a, b, cin));
        #1;
        obs = observe(1'b0);
        n_vec++;
        if (obs !== 7'b0000000) begin
            n_err++;
            $display("FAIL reset_release: got %b required 0000000", obs);
        end
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        obs = observe(cin);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL reset_first_capture: got %b required %b", obs, exp);
        end
    endtask

    task automatic test_directed();
        // Each entry is {A, B, CIN, S, Gg, Pg, COUT}
        logic [15:0] tbl [6];
        logic [15:0] e;
        res_t        obs;
        res_t        exp;
        tbl[0] = {4'b1000, 4'b0111, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b0};
        tbl[1] = {4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0, 1'b1, 1'b0};
        tbl[2] = {4'b0110, 4'b0011, 1'b0, 4'b1001, 1'b0, 1'b0, 1'b0};
        tbl[3] = {4'b1001, 4'b0100, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0};
        tbl[4] = {4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1};
        tbl[5] = {4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            e   = tbl[i];
            a   = e[15:12];
            b   = e[11:8];
            cin = e[7];
            sb.push_back(res_t'(e[6:0]));
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            obs = observe(cin);
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL directed[%0d] a=%b b=%b cin=%b: got %b required %b",
                         i, a, b, cin, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t obs;
        res_t exp;
        res_t prev;
        logic prev_cin;
        prev     = model(a, b, cin);
        prev_cin = cin;
        for (int i = 0; i < 24; i++) begin
            a   = 4'($urandom_range(15, 0));
            b   = 4'($urandom_range(15, 0));
            cin = 1'($urandom_range(1, 0));
            sb.push_back(model(a, b, cin));
            // New inputs must not reach the outputs before the edge
            #1;
            obs = observe(prev_cin);
            n_vec++;
            if (obs !== prev) begin
                n_err++;
                $display("FAIL b2b_hold[%0d]: got %b required %b", i, obs, prev);
            end
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            obs = observe(cin);
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL b2b[%0d] a=%h b=%h cin=%b: got %b required %b",
                         i, a, b, cin, obs, exp);
            end
            prev     = exp;
            prev_cin = cin;
        end
    endtask

    task automatic test_sweep();
        res_t obs;
        res_t exp;
        for (int i = 0; i < 512; i++) begin
            a   = 4'(i[8:5]);
            b   = 4'(i[4:1]);
            cin = i[0];
            sb.push_back(model(a, b, cin));
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            obs = observe(cin);
            n_vec++;
            if (obs !== exp || (gg_o === 1'b1 && pg_o === 1'b1)) begin
                n_err++;
                $display("FAIL sweep a=%h b=%h cin=%b: got %b required %b",
                         a, b, cin, obs, exp);
            end
            if (i == 255) begin
                rst = 1'b1;
                #1;
                obs = observe(1'b0);
                n_vec++;
                if (obs !== 7'b0000000) begin
                    n_err++;
                    $display("FAIL sweep_reset_async: got %b required 0000000", obs);
                end
                #1;
                rst = 1'b0;
                #1;
                obs = observe(1'b0);
                n_vec++;
                if (obs !== 7'b0000000) begin
                    n_err++;
                    $display("FAIL sweep_reset_release: got %b required 0000000", obs);
                end
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
